// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: snapshots one pipeline stage per cycle into a ring, freezes after a trigger.
// Define TRACE_PRINT_EN for a simulation-only printer of captured records and transitions.
module pipe_trace_buffer #(
  parameter int NUM_STAGES = 5,
  parameter int DEPTH      = 64,
  parameter int POST_TRIG  = 16,
  parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_STAGES-1:0]   i_stage_valid,
  input  logic [NUM_STAGES*32-1:0] i_stage_pc,
  input  logic [NUM_STAGES*32-1:0] i_stage_instr,
  input  logic [NUM_STAGES*32-1:0] i_stage_result,
  input  logic [NUM_STAGES*5-1:0] i_stage_rd,
  input  logic [NUM_STAGES-1:0]   i_stage_we,
  input  logic [STAGE_W-1:0]      i_stage_sel,
  input  logic                    i_arm,
  input  logic [31:0]             i_trig_pc,
  input  logic                    i_trig_force,
  input  logic                    i_rd_req,
  output logic                    o_rd_valid,
  output logic [133:0]            o_rd_data,
  output logic                    o_rd_last,
  output logic [1:0]              o_state,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam int RW = 134;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [STAGE_W-1:0] sel_q, sel_d;
  logic [31:0]    tpc_q, tpc_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  post_q, post_d;
  logic [31:0]    cyc_q, cyc_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_last_q, rd_last_d;
  logic [RW-1:0]  rd_data_q, rd_data_d;

  logic [RW-1:0]  mem_q [DEPTH];

  logic [31:0]    pc_a  [NUM_STAGES];
  logic [31:0]    ins_a [NUM_STAGES];
  logic [31:0]    res_a [NUM_STAGES];
  logic [4:0]     rd_a  [NUM_STAGES];

  logic [STAGE_W-1:0] sidx;
  logic           cur_v;
  logic           cur_we;
  logic [31:0]    cur_pc;
  logic [31:0]    cur_ins;
  logic [31:0]    cur_res;
  logic [4:0]     cur_rd;
  logic [RW-1:0]  rec;
  logic           capture;
  logic           pc_hit;
  logic           wr_en;

  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      pc_a[s]  = i_stage_pc[s*32 +: 32];
      ins_a[s] = i_stage_instr[s*32 +: 32];
      res_a[s] = i_stage_result[s*32 +: 32];
      rd_a[s]  = i_stage_rd[s*5 +: 5];
    end
  end

  // An out-of-range select never captures.
  always_comb begin
    sidx    = (int'(sel_q) < NUM_STAGES) ? sel_q : '0;
    cur_v   = (int'(sel_q) < NUM_STAGES) && i_stage_valid[sidx];
    cur_we  = i_stage_we[sidx];
    cur_pc  = pc_a[sidx];
    cur_ins = ins_a[sidx];
    cur_res = res_a[sidx];
    cur_rd  = rd_a[sidx];
    rec     = {cyc_q, cur_pc, cur_ins, cur_res, cur_rd, cur_we};
    capture = ((state_q == S_ARMED) || (state_q == S_POST)) && cur_v;
    pc_hit  = capture && (cur_pc == tpc_q);
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tpc_d      = tpc_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    post_d     = post_q;
    cyc_d      = cyc_q + 32'd1;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_data_d  = rd_data_q;
    wr_en      = 1'b0;
    if (i_arm) begin
      state_d  = S_ARMED;
      sel_d    = i_stage_sel;
      tpc_d    = i_trig_pc;
      wr_ptr_d = '0;
      cnt_d    = '0;
      post_d   = '0;
    end else begin
      if (capture) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + 1'b1;
      end
      unique case (state_q)
        S_ARMED: begin
          if (pc_hit || i_trig_force) begin
            if (POST_TRIG == 0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
              post_d  = PW'(POST_TRIG);
            end
          end
        end
        S_POST: begin
          if (capture) begin
            post_d = post_q - 1'b1;
            if (post_q == PW'(1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else if (i_rd_req) begin
            rd_valid_d = 1'b1;
            rd_last_d  = (cnt_q == CW'(1));
            rd_data_d  = mem_q[rd_ptr_q];
            cnt_d      = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Oldest entry sits count slots behind the write pointer.
    rd_ptr_d = wr_ptr_d - cnt_d[AW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (wr_en && !i_rst) mem_q[wr_ptr_q] <= rec;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      tpc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      post_q     <= '0;
      cyc_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tpc_q      <= tpc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      post_q     <= post_d;
      cyc_q      <= cyc_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_last  = rd_last_q;
  assign o_rd_data  = rd_data_q;
  assign o_state    = state_q;
  assign o_count    = cnt_q;

`ifdef TRACE_PRINT_EN
  always @(negedge i_clk) begin
    if (!i_rst && wr_en)
      $write("TRC stage%0d cyc %d PC %h I %h rd %d we %d res %h\n",
             sel_q, cyc_q, cur_pc, cur_ins, cur_rd, cur_we, cur_res);
    if (!i_rst && !i_arm && state_q == S_ARMED && state_d != S_ARMED)
      $write("TRIGGER\n");
    if (!i_rst && !i_arm && state_q != S_DONE && state_d == S_DONE)
      $write("DONE\n");
  end
`endif

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer: two DUTs (POST_TRIG 2 and 0) share stimulus and are scored
// against a queue-based model of the trace session.
`timescale 1ns/1ps
module tb_pipe_trace_buffer;
  localparam int NS    = 5;
  localparam int DEPTH = 8;
  typedef logic [133:0] rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, arm, tforce, rd_req;
  logic [2:0]    sel;
  logic [31:0]   tpc;
  logic [NS-1:0] sv, swe;
  logic [31:0]   pc_a  [NS];
  logic [31:0]   ins_a [NS];
  logic [31:0]   res_a [NS];
  logic [4:0]    rd_a  [NS];
  logic [NS*32-1:0] spc, sins, sres;
  logic [NS*5-1:0]  srd;

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      spc[s*32 +: 32]  = pc_a[s];
      sins[s*32 +: 32] = ins_a[s];
      sres[s*32 +: 32] = res_a[s];
      srd[s*5 +: 5]    = rd_a[s];
    end
  end

  logic [1:0] o_st  [2];
  logic [3:0] o_cnt [2];
  logic       rv    [2];
  logic       rl    [2];
  rec_t       rdat  [2];

  pipe_trace_buffer #(.NUM_STAGES(NS), .DEPTH(DEPTH), .POST_TRIG(2)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_stage_valid(sv), .i_stage_pc(spc), .i_stage_instr(sins),
    .i_stage_result(sres), .i_stage_rd(srd), .i_stage_we(swe),
    .i_stage_sel(sel), .i_arm(arm), .i_trig_pc(tpc),
    .i_trig_force(tforce), .i_rd_req(rd_req),
    .o_rd_valid(rv[0]), .o_rd_data(rdat[0]), .o_rd_last(rl[0]),
    .o_state(o_st[0]), .o_count(o_cnt[0])
  );

  pipe_trace_buffer #(.NUM_STAGES(NS), .DEPTH(DEPTH), .POST_TRIG(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_stage_valid(sv), .i_stage_pc(spc), .i_stage_instr(sins),
    .i_stage_result(sres), .i_stage_rd(srd), .i_stage_we(swe),
    .i_stage_sel(sel), .i_arm(arm), .i_trig_pc(tpc),
    .i_trig_force(tforce), .i_rd_req(rd_req),
    .o_rd_valid(rv[1]), .o_rd_data(rdat[1]), .o_rd_last(rl[1]),
    .o_state(o_st[1]), .o_count(o_cnt[1])
  );

  // Reference model: a session is a bounded queue of records, oldest at the front.
  rec_t         mbuf [2][$];
  logic [134:0] eq   [2][$];
  int           mst  [2];
  int           mrem [2];
  logic [2:0]   msel [2];
  logic [31:0]  mtpc [2];
  logic [31:0]  mcyc;
  logic         mrst = 1'b0;

  function automatic int ptrig(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  always @(posedge clk) begin
    logic v;
    rec_t r;
    mrst = rst;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mst[k] = 0;
        mrem[k] = 0;
        mbuf[k].delete();
      end else if (arm) begin
        mst[k] = 1;
        msel[k] = sel;
        mtpc[k] = tpc;
        mbuf[k].delete();
      end else if (mst[k] == 1 || mst[k] == 2) begin
        v = (int'(msel[k]) < NS) ? sv[msel[k]] : 1'b0;
        r = {mcyc, pc_a[msel[k]], ins_a[msel[k]], res_a[msel[k]],
             rd_a[msel[k]], swe[msel[k]]};
        if (v) begin
          mbuf[k].push_back(r);
          if (mbuf[k].size() > DEPTH) void'(mbuf[k].pop_front());
        end
        if (mst[k] == 1) begin
          if ((v && pc_a[msel[k]] == mtpc[k]) || tforce) begin
            if (ptrig(k) == 0) mst[k] = 3;
            else begin
              mst[k] = 2;
              mrem[k] = ptrig(k);
            end
          end
        end else if (v) begin
          mrem[k] = mrem[k] - 1;
          if (mrem[k] == 0) mst[k] = 3;
        end
      end else if (mst[k] == 3) begin
        if (mbuf[k].size() == 0) mst[k] = 0;
        else if (rd_req) begin
          r = mbuf[k].pop_front();
          eq[k].push_back({mbuf[k].size() == 0, r});
        end
      end
    end
    if (rst) mcyc = 32'd0;
    else mcyc = mcyc + 32'd1;
  end

  int checks = 0;
  int errors = 0;
  int tmo = 0;
  bit mon_en = 1'b0;
  bit fin_req = 1'b0;
  bit fin_done = 1'b0;

  always @(negedge clk) begin
    logic [134:0] e;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_st[k] !== 2'(mst[k])) begin
          errors++;
          $display("FAIL state dut%0d got %0d want %0d", k, o_st[k], mst[k]);
        end
        checks++;
        if (int'(o_cnt[k]) != mbuf[k].size()) begin
          errors++;
          $display("FAIL count dut%0d got %0d want %0d", k, o_cnt[k], mbuf[k].size());
        end
        checks++;
        if (rv[k] === 1'b1) begin
          if (eq[k].size() == 0) begin
            errors++;
            $display("FAIL spurious_rd_valid dut%0d got 1 want 0", k);
          end else begin
            e = eq[k].pop_front();
            if ({rl[k], rdat[k]} !== e) begin
              errors++;
              $display("FAIL rd_data dut%0d got %h want %h", k, {rl[k], rdat[k]}, e);
            end
          end
        end else if (eq[k].size() != 0 || rl[k] !== 1'b0 || rv[k] !== 1'b0) begin
          errors++;
          $display("FAIL missing_rd_valid dut%0d got rv %b rl %b want rv %0d rl 0",
                   k, rv[k], rl[k], eq[k].size() != 0);
          if (eq[k].size() != 0) void'(eq[k].pop_front());
        end
        if (mrst) begin
          checks++;
          if (rdat[k] !== '0) begin
            errors++;
            $display("FAIL reset_rd_data dut%0d got %h want 0", k, rdat[k]);
          end
        end
      end
      if (fin_req && !fin_done) begin
        checks++;
        if (tmo != 0) begin
          errors++;
          $display("FAIL timeout got %0d want 0", tmo);
        end
        fin_done = 1'b1;
      end
    end
  end

  task automatic rand_stages();
    for (int s = 0; s < NS; s++) begin
      sv[s]    = ($urandom_range(0, 3) != 0);
      pc_a[s]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      ins_a[s] = $urandom;
      res_a[s] = $urandom;
      rd_a[s]  = 5'($urandom);
      swe[s]   = 1'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0;
    arm = 1'b0;
    tforce = 1'b0;
    rd_req = 1'b0;
    rand_stages();
  endtask

  task automatic put4(input logic v, input logic [31:0] pc);
    sv[4] = v;
    pc_a[4] = pc;
  endtask

  task automatic start(input logic [2:0] s, input logic [31:0] p);
    arm = 1'b1;
    sel = s;
    tpc = p;
    step();
  endtask

  task automatic drain(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b1;
      step();
      if (gap) step();
    end
  endtask

  task automatic wait_st(input int k, input logic [1:0] s);
    for (int i = 0; i < 200 && o_st[k] != s; i++) step();
    if (o_st[k] != s) tmo++;
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    tforce = 1'b0;
    rd_req = 1'b0;
    sel = '0;
    tpc = '0;
    rand_stages();
    step();
    mon_en = 1'b1;
    rd_req = 1'b1;
    step();
    rd_req = 1'b1;
    step();

    start(3'd4, 32'h40);
    for (int i = 0; i < 20; i++) begin
      put4(1'b1, 32'(i * 4));
      step();
    end
    wait_st(0, 2'd3);
    drain(12, 1'b1);

    start(3'd4, 32'h40);
    for (int i = 0; i < 24; i++) begin
      put4(i % 2 == 0, 32'(i * 4));
      step();
    end
    wait_st(0, 2'd3);
    drain(10, 1'b0);

    start(3'd4, 32'hFFFF_FFF0);
    for (int i = 0; i < 5; i++) begin
      put4(1'b1, 32'h80 + 32'(i * 4));
      step();
    end
    put4(1'b1, 32'h100);
    tforce = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      put4(1'b1, 32'h104 + 32'(i * 4));
      step();
    end
    wait_st(0, 2'd3);
    drain(10, 1'b1);

    start(3'd2, 32'hFFFF_FFF0);
    sv[2] = 1'b0;
    tforce = 1'b1;
    step();
    for (int i = 0; i < 8; i++) step();
    drain(4, 1'b0);

    start(3'd4, 32'h40);
    for (int i = 0; i < 16; i++) begin
      put4(1'b1, 32'(i * 4));
      step();
    end
    put4(1'b1, 32'h40);
    arm = 1'b1;
    sel = 3'd4;
    tpc = 32'h40;
    step();
    for (int i = 0; i < 3; i++) begin
      put4(1'b1, 32'h200 + 32'(i * 4));
      rd_req = 1'b1;
      step();
    end
    put4(1'b1, 32'h300);
    tforce = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      put4(1'b1, 32'h304 + 32'(i * 4));
      step();
    end
    wait_st(0, 2'd3);
    drain(10, 1'b0);

    start(3'd4, 32'h40);
    for (int i = 0; i < 18; i++) begin
      put4(1'b1, 32'(i * 4));
      step();
    end
    rst = 1'b1;
    step();
    rd_req = 1'b1;
    step();
    step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        arm = 1'b1;
        sel = 3'($urandom_range(0, 4));
        tpc = ($urandom_range(0, 3) == 0) ? $urandom
                                          : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      tforce = ($urandom_range(0, 79) == 0);
      rd_req = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 999) == 0);
      step();
    end

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) @(posedge clk);
    if (!fin_done) begin
      $display("FAIL finish got 0 want 1");
      $fatal(1, "monitor stalled");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Synthesizable, parametrised pipeline trace capture unit for the riscv32i core. Each cycle it snapshots one selectable pipeline stage into a circular buffer. On a PC-match or forced trigger it records a programmable number of post-trigger entries, then freezes. The frozen contents are read out oldest-first over a request/valid handshake. It sits beside the pipeline registers and replaces print-only debug tracing for on-chip use.

Parameters:
NUM_STAGES, 5, number of pipeline stages presented on the packed stage inputs
DEPTH, 64, buffer entries; must be a power of 2 and at least 4
POST_TRIG, 16, entries captured after the trigger entry; must satisfy POST_TRIG <= DEPTH-1
STAGE_W, $clog2(NUM_STAGES) (min 1), stage-select width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_stage_valid  in  NUM_STAGES  per-stage valid; bit s = stage s holds a real instruction
i_stage_pc  in  NUM_STAGES*32  packed PCs; stage s = [32s+31:32s]
i_stage_instr  in  NUM_STAGES*32  packed instruction words
i_stage_result  in  NUM_STAGES*32  packed alu_res1 / rd_data values
i_stage_rd  in  NUM_STAGES*5  packed destination register indices
i_stage_we  in  NUM_STAGES  packed reg_write_en flags
i_stage_sel  in  STAGE_W  stage to trace; sampled only on i_arm
i_arm  in  1  pulse; start a capture session
i_trig_pc  in  32  trigger PC; sampled on i_arm
i_trig_force  in  1  pulse; immediate trigger
i_rd_req  in  1  pulse; request the next stored record
o_rd_valid  out  1  o_rd_data is valid this cycle (one-cycle pulse)
o_rd_data  out  134  {cycle[31:0], pc[31:0], instr[31:0], result[31:0], rd[4:0], we}
o_rd_last  out  1  qualifies o_rd_valid; oldest-first read of the final entry
o_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
o_count  out  $clog2(DEPTH)+1  number of valid entries, saturates at DEPTH

Behaviour:
- Reset: o_state=IDLE; o_rd_valid=0, o_rd_last=0, o_rd_data=0, o_count=0; write pointer, read pointer, post counter and cycle stamp all 0. Reset mid-session aborts the session and discards buffer contents.
- Cycle stamp: a free-running 32-bit counter increments every cycle and wraps from 0xFFFFFFFF to 0.
- Capture event: a cycle with state in {ARMED, POST} and i_stage_valid[sel]=1. The record is written at the write pointer, then the write pointer increments mod DEPTH. o_count increments and saturates at DEPTH; when full, the oldest entry is overwritten.
- IDLE -> ARMED on i_arm. Latch sel and trig_pc, clear o_count and both pointers.
- ARMED: capture continuously. Trigger = capture event with pc == trig_pc, or i_trig_force. On trigger, go to POST with post counter = POST_TRIG.
  - The trigger record is always stored.
  - A forced trigger with no valid stage stores nothing that cycle.
- POST: each capture event decrements the post counter. After the POST_TRIG-th post-trigger capture, go to DONE in the same cycle as that write. If POST_TRIG=0, the trigger itself moves ARMED -> DONE. Triggers are ignored while in POST.
- DONE: capture is stopped. Read pointer = (wr_ptr - o_count) mod DEPTH.
  - i_rd_req: o_rd_valid pulses the next cycle with the entry at the read pointer; the read pointer advances and o_count decrements.
  - o_rd_last=1 on the read that brings o_count to 0; the state goes to IDLE on the cycle after that read is presented.
  - i_rd_req while o_count=0, or in any state other than DONE, is ignored.
- i_arm in ARMED, POST or DONE restarts the session from empty, discarding contents. i_arm has priority over a same-cycle trigger or i_rd_req.
- No combinational path from any input to any output.

Optional Feature:
TRACE_PRINT_EN: when defined, a simulation-only negedge block $writes each captured record as "TRC stage%0d cyc %d PC %h I %h rd %d we %d res %h", plus "TRIGGER" and "DONE" lines on those transitions. Without the macro, no $write/$display code exists and the block is fully synthesizable. Captured and read data are identical either way.

Test Plan:
- Reset mid-POST (i_rst high 1 cycle) -> o_state=0, o_count=0, o_rd_valid=0 next cycle; a following i_rd_req gives no o_rd_valid.
- DEPTH=8, POST_TRIG=2, sel=4, trig_pc=0x40; feed PCs 0x00,0x04,...,0x4C one per cycle, all valid -> DONE after PC 0x48; o_count=8; eight reads return 0x2C..0x48 in order; o_rd_last only on 0x48.
- Same config with i_stage_valid[4] low on alternate cycles -> only valid-cycle PCs stored; cycle stamps strictly increasing by 2.
- POST_TRIG=0, i_trig_force pulse while valid PC 0x100 -> DONE the same cycle; o_count equals entries captured so far, last read = PC 0x100.
- i_arm in the same cycle as a trig_pc match in ARMED -> session restarts, o_state=ARMED, o_count=0, no trigger taken.
- i_rd_req in IDLE and in ARMED -> no o_rd_valid; pointers and o_count unchanged.
